// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: quad-SPI serial SRAM controller. It turns single-word core requests into CMD/ADDR/DUMMY/DATA nibble streams.
// Optional sequential-burst continuation is enabled by defining IDLI_SQI_BURST_EN.
package idli_pkg;
    typedef enum logic {
        SQI_MODE_IN  = 1'b0,
        SQI_MODE_OUT = 1'b1
    } sqi_mode_t;
endpackage

module idli_sqi_ctrl
    import idli_pkg::*;
#(
    parameter int  NUM_CHIPS    = 2,
    parameter int  ADDR_W       = 24,
    parameter int  DATA_NIBBLES = 4,
    localparam int CHIP_W       = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    localparam int W            = 4 * DATA_NIBBLES
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    output logic                 o_ready,
    input  logic                 i_we,
    input  logic [CHIP_W-1:0]    i_chip,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [W-1:0]         i_wdata,
    output logic                 o_done,
    output logic [W-1:0]         o_rdata,
    output logic                 o_sqi_sck,
    output logic [NUM_CHIPS-1:0] o_sqi_cs_n,
    output logic [3:0]           o_sqi_sio,
    input  logic [3:0]           i_sqi_sio,
    output sqi_mode_t            o_sqi_mode,
    output logic [2:0]           o_dbg_state
);

    localparam int A     = ADDR_W / 4;
    localparam int D     = DATA_NIBBLES;
    localparam int CNT_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    logic [2:0]        state;
    logic              phase;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  last_cnt;
    logic              we_q;
    logic [CHIP_W-1:0] chip_q;
    logic [ADDR_W-1:0] addr_sh;
    logic [W-1:0]      wd_sh;
    logic [W-5:0]      rx_sh;
    logic [W-1:0]      rx_next;
    logic              pend_q;
    logic              chip_ok;
    logic              last_nib;
    logic              burst_slot;
    logic              seq_cont;
    logic              accept;
    logic              active;

    // Handshake: a request transfers on any cycle where i_req && o_ready.
    assign chip_ok  = (int'(chip_q) < NUM_CHIPS);
    assign rx_next  = {rx_sh, i_sqi_sio};
    assign last_nib = (cnt == last_cnt);

    always_comb begin
        last_cnt = '0;
        case (state)
            ST_CMD, ST_DUMMY: last_cnt = CNT_W'(1);
            ST_ADDR:          last_cnt = CNT_W'(A - 1);
            ST_DATA:          last_cnt = CNT_W'(D - 1);
            default:          last_cnt = '0;
        endcase
    end

`ifdef IDLI_SQI_BURST_EN
    logic [ADDR_W-1:0] addr_q;

    // The final DATA nibble's high phase doubles as an acceptance slot for a follow-on request.
    assign burst_slot = (state == ST_DATA) && phase && last_nib;
    assign seq_cont   = burst_slot && (i_we == we_q) && (i_chip == chip_q) &&
                        (i_addr == addr_q + ADDR_W'(D / 2));
`else
    assign burst_slot = 1'b0;
    assign seq_cont   = 1'b0;
`endif

    assign o_ready     = (state == ST_IDLE) || burst_slot;
    assign accept      = i_req && o_ready;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            phase   <= 1'b0;
            cnt     <= '0;
            we_q    <= 1'b0;
            chip_q  <= '0;
            addr_sh <= '0;
            wd_sh   <= '0;
            rx_sh   <= '0;
            pend_q  <= 1'b0;
            o_done  <= 1'b0;
            o_rdata <= '0;
`ifdef IDLI_SQI_BURST_EN
            addr_q  <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    phase <= 1'b0;
                    cnt   <= '0;
                    if (accept) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    phase <= ~phase;
                    // Everything advances at the edge that closes the SCK-high phase.
                    if (phase) begin
                        cnt <= last_nib ? '0 : cnt + 1'b1;
                        if (state == ST_ADDR) begin
                            addr_sh <= addr_sh << 4;
                        end
                        if (state == ST_DATA) begin
                            if (we_q) begin
                                wd_sh <= wd_sh << 4;
                            end else begin
                                rx_sh <= rx_next[W-5:0];
                            end
                        end
                        if (last_nib) begin
                            case (state)
                                ST_CMD:   state <= ST_ADDR;
                                ST_ADDR:  state <= we_q ? ST_DATA : ST_DUMMY;
                                ST_DUMMY: state <= ST_DATA;
                                default: begin
                                    o_done <= 1'b1;
                                    if (!we_q) begin
                                        o_rdata <= chip_ok ? rx_next : '0;
                                    end
                                    if (seq_cont) begin
                                        state <= ST_DATA;
                                    end else begin
                                        state  <= ST_END;
                                        pend_q <= accept;
                                    end
                                end
                            endcase
                        end
                    end
                end
                ST_END: begin
                    phase <= ~phase;
                    if (phase) begin
                        state  <= pend_q ? ST_CMD : ST_IDLE;
                        pend_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    phase <= 1'b0;
                end
            endcase

            if (accept) begin
                we_q    <= i_we;
                chip_q  <= i_chip;
                addr_sh <= i_addr;
                wd_sh   <= i_wdata;
`ifdef IDLI_SQI_BURST_EN
                addr_q  <= i_addr;
`endif
            end
        end
    end

    always_comb begin
        o_sqi_sio  = 4'h0;
        o_sqi_mode = SQI_MODE_IN;
        o_sqi_cs_n = '1;
        active     = 1'b0;
        case (state)
            ST_CMD: begin
                active     = 1'b1;
                o_sqi_mode = SQI_MODE_OUT;
                o_sqi_sio  = cnt[0] ? (we_q ? 4'h2 : 4'h3) : 4'h0;
            end
            ST_ADDR: begin
                active     = 1'b1;
                o_sqi_mode = SQI_MODE_OUT;
                o_sqi_sio  = addr_sh[ADDR_W-1 -: 4];
            end
            ST_DUMMY: begin
                active = 1'b1;
            end
            ST_DATA: begin
                active = 1'b1;
                if (we_q) begin
                    o_sqi_mode = SQI_MODE_OUT;
                    o_sqi_sio  = wd_sh[W-1 -: 4];
                end
            end
            default: begin
                active = 1'b0;
            end
        endcase
        o_sqi_sck = active & phase;
        // An out-of-range chip index runs the sequence with every select left high.
        if (active && chip_ok) begin
            for (int i = 0; i < NUM_CHIPS; i++) begin
                if (int'(chip_q) == i) begin
                    o_sqi_cs_n[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Directed bench for idli_sqi_ctrl: cycle-indexed request/chip-data schedule, per-cycle output log, checks against hand-computed streams.
`timescale 1ns/1ps
module tb_idli_sqi_ctrl;
  import idli_pkg::*;

  localparam int NC = 3;
  localparam int NT = 80;
  localparam int T0 = 1;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        ready;
  logic        we;
  logic [1:0]  chip;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic        done;
  logic [15:0] rdata;
  logic        sck;
  logic [2:0]  cs_n;
  logic [3:0]  sio_o;
  logic [3:0]  sio_i;
  sqi_mode_t   mode;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  logic [3:0]  sio_log[NT];
  logic [2:0]  cs_log[NT];
  logic        out_log[NT];
  logic        sck_log[NT];
  logic        done_log[NT];
  logic        ready_log[NT];
  logic [15:0] rdata_log[NT];

  logic        req_s[NT];
  logic        we_s[NT];
  logic [1:0]  chip_s[NT];
  logic [23:0] addr_s[NT];
  logic [15:0] wd_s[NT];
  logic [3:0]  sio_s[NT];

  idli_sqi_ctrl #(.NUM_CHIPS(NC), .ADDR_W(24), .DATA_NIBBLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(ready), .i_we(we),
    .i_chip(chip), .i_addr(addr), .i_wdata(wdata), .o_done(done), .o_rdata(rdata),
    .o_sqi_sck(sck), .o_sqi_cs_n(cs_n), .o_sqi_sio(sio_o), .i_sqi_sio(sio_i),
    .o_sqi_mode(mode), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic clear_sched();
    for (int t = 0; t < NT; t++) begin
      req_s[t] = 1'b0; we_s[t] = 1'b0; chip_s[t] = 2'd0;
      addr_s[t] = 24'h0; wd_s[t] = 16'h0; sio_s[t] = 4'h7;
    end
  endtask

  task automatic sched_req(input int t, input logic w, input logic [1:0] c,
                           input logic [23:0] a, input logic [15:0] d);
    req_s[t] = 1'b1; we_s[t] = w; chip_s[t] = c; addr_s[t] = a; wd_s[t] = d;
  endtask

  // Chip drives each nibble during the SCK-high half of its DATA slot; junk 7 elsewhere.
  task automatic sched_read_data(input int t_data, input logic [15:0] drive, input logic [15:0] expect_rd);
    for (int n = 0; n < 4; n++) begin
      sio_s[t_data + 2*n + 1] = drive[15 - 4*n -: 4];
    end
    exp_q.push_back(expect_rd);
  endtask

  task automatic run(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      sio_log[t] = sio_o; cs_log[t] = cs_n; out_log[t] = (mode == SQI_MODE_OUT);
      sck_log[t] = sck; done_log[t] = done; ready_log[t] = ready; rdata_log[t] = rdata;
      req = req_s[t]; we = we_s[t]; chip = chip_s[t]; addr = addr_s[t];
      wdata = wd_s[t]; sio_i = sio_s[t];
    end
  endtask

  function automatic logic [63:0] stream(input int t_cmd, input int n);
    logic [63:0] s = '0;
    for (int k = 0; k < n; k++) s = {s[59:0], sio_log[t_cmd + 2*k + 1]};
    return s;
  endfunction

  function automatic int first_done(input int from, input int to);
    for (int t = from; t <= to; t++) if (done_log[t]) return t;
    return -1;
  endfunction

  function automatic int count_done(input int from, input int to);
    int c = 0;
    for (int t = from; t <= to; t++) if (done_log[t]) c++;
    return c;
  endfunction

  function automatic int cs_bad(input int from, input int to, input logic [2:0] e);
    int c = 0;
    for (int t = from; t <= to; t++) if (cs_log[t] !== e) c++;
    return c;
  endfunction

  function automatic int mode_bad(input int from, input int to, input logic e_out);
    int c = 0;
    for (int t = from; t <= to; t++) if (out_log[t] !== e_out) c++;
    return c;
  endfunction

  function automatic int sck_bad(input int from, input int to);
    int c = 0;
    for (int t = from; t <= to; t++) if (sck_log[t] !== 1'((t - from) % 2)) c++;
    return c;
  endfunction

  function automatic int first_in(input int from, input int to);
    for (int t = from; t <= to; t++) if (!out_log[t]) return t;
    return -1;
  endfunction

  // scoreboard: read data at o_done against the expected queue
  task automatic check_rdata(input string tag, input int t);
    logic [15:0] e;
    check_eq({tag, "_pending"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(tag, 64'(rdata_log[t]), 64'(e));
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; chip = 2'd0; addr = 24'h0; wdata = 16'h0; sio_i = 4'h0;
    clear_sched();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    check_eq("rst_sck", 64'(sck), 64'd0);
    check_eq("rst_cs", 64'(cs_n), 64'h7);
    check_eq("rst_sio", 64'(sio_o), 64'd0);
    check_eq("rst_mode", 64'(mode == SQI_MODE_OUT), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 64'(ready), 64'd1);
    check_eq("rel_sck", 64'(sck), 64'd0);

    // write chip 0, 0x000010, 0xBEEF
    clear_sched();
    sched_req(0, 1'b1, 2'd0, 24'h000010, 16'hBEEF);
    run(32);
    check_eq("wr_accept", 64'(ready_log[0]), 64'd1);
    check_eq("wr_stream", stream(T0, 12), 64'h0200_0010_BEEF);
    check_eq("wr_cs", 64'(cs_bad(T0, T0 + 23, 3'b110)), 64'd0);
    check_eq("wr_cs_end", 64'({cs_log[T0 + 24], cs_log[T0 + 25]}), 64'h3F);
    check_eq("wr_mode", 64'(mode_bad(T0, T0 + 23, 1'b1)), 64'd0);
    check_eq("wr_sck", 64'(sck_bad(T0, T0 + 23)), 64'd0);
    check_eq("wr_done_at", 64'(first_done(0, 31)), 64'(T0 + 24));
    check_eq("wr_done_cnt", 64'(count_done(0, 31)), 64'd1);
    check_eq("wr_busy_end", 64'(ready_log[T0 + 25]), 64'd0);
    check_eq("wr_ready_back", 64'(ready_log[T0 + 26]), 64'd1);

    // read chip 1, 0x00ABCD, chip returns A5A5
    clear_sched();
    sched_req(0, 1'b0, 2'd1, 24'h00ABCD, 16'h0);
    sched_read_data(T0 + 20, 16'hA5A5, 16'hA5A5);
    run(32);
    check_eq("rd_stream", stream(T0, 8), 64'h0300ABCD);
    check_eq("rd_mode_out", 64'(mode_bad(T0, T0 + 15, 1'b1)), 64'd0);
    check_eq("rd_mode_in_at", 64'(first_in(T0, 31)), 64'(T0 + 16));
    check_eq("rd_mode_in", 64'(mode_bad(T0 + 16, T0 + 27, 1'b0)), 64'd0);
    check_eq("rd_cs", 64'(cs_bad(T0, T0 + 27, 3'b101)), 64'd0);
    check_eq("rd_done_at", 64'(first_done(0, 31)), 64'(T0 + 28));
    check_rdata("rd_data", T0 + 28);
    check_eq("rd_hold", 64'(rdata_log[T0 + 30]), 64'hA5A5);
`ifndef IDLI_SQI_BURST_EN
    check_eq("rd_no_burst_slot", 64'(ready_log[T0 + 27]), 64'd0);
`endif

    // reset in the middle of a read
    clear_sched();
    sched_req(0, 1'b0, 2'd1, 24'h00ABCD, 16'h0);
    run(11);
    check_eq("mid_cs_active", 64'(cs_log[10]), 64'b101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cs", 64'(cs_n), 64'h7);
    check_eq("mid_rst_mode", 64'(mode == SQI_MODE_OUT), 64'd0);
    check_eq("mid_rst_sck", 64'(sck), 64'd0);
    check_eq("mid_rst_ready", 64'(ready), 64'd1);
    check_eq("mid_rst_rdata", 64'(rdata), 64'd0);
    check_eq("mid_rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_sched();
    run(32);
    check_eq("mid_no_done", 64'(count_done(0, 31)), 64'd0);
    clear_sched();
    sched_req(0, 1'b0, 2'd2, 24'h123456, 16'h0);
    sched_read_data(T0 + 20, 16'h3C96, 16'h3C96);
    run(32);
    check_eq("post_stream", stream(T0, 8), 64'h03123456);
    check_eq("post_cs", 64'(cs_bad(T0, T0 + 27, 3'b011)), 64'd0);
    check_eq("post_done_at", 64'(first_done(0, 31)), 64'(T0 + 28));
    check_rdata("post_data", T0 + 28);

    // out-of-range chip index
    clear_sched();
    sched_req(0, 1'b0, 2'd3, 24'h000040, 16'h0);
    sched_read_data(T0 + 20, 16'hFFFF, 16'h0000);
    run(32);
    check_eq("bad_chip_cs", 64'(cs_bad(0, 31, 3'b111)), 64'd0);
    check_eq("bad_chip_done_at", 64'(first_done(0, 31)), 64'(T0 + 28));
    check_rdata("bad_chip_data", T0 + 28);

`ifdef IDLI_SQI_BURST_EN
    // sequential continuation, then a non-sequential follow-on
    clear_sched();
    sched_req(0, 1'b0, 2'd0, 24'h000100, 16'h0);
    sched_read_data(21, 16'h1234, 16'h1234);
    sched_req(28, 1'b0, 2'd0, 24'h000102, 16'h0);
    sched_read_data(29, 16'h5678, 16'h5678);
    sched_req(36, 1'b0, 2'd0, 24'h000200, 16'h0);
    sched_read_data(59, 16'h9ABC, 16'h9ABC);
    run(72);
    check_eq("bu_slot1", 64'(ready_log[28]), 64'd1);
    check_eq("bu_slot2", 64'(ready_log[36]), 64'd1);
    check_eq("bu_cs_held", 64'(cs_bad(1, 36, 3'b110)), 64'd0);
    check_eq("bu_no_cmd", 64'(mode_bad(29, 36, 1'b0)), 64'd0);
    check_eq("bu_done1", 64'(first_done(0, 71)), 64'd29);
    check_rdata("bu_data1", 29);
    check_eq("bu_done2", 64'(first_done(30, 71)), 64'd37);
    check_rdata("bu_data2", 37);
    check_eq("bu_cs_gap", 64'({cs_log[37], cs_log[38]}), 64'h3F);
    check_eq("bu_cs_again", 64'(cs_log[39]), 64'b110);
    check_eq("bu_stream3", stream(39, 8), 64'h03000200);
    check_eq("bu_done3", 64'(first_done(38, 71)), 64'd67);
    check_rdata("bu_data3", 67);
    check_eq("bu_done_cnt", 64'(count_done(0, 71)), 64'd3);
`endif

    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idli_sqi_ctrl.md
# idli_sqi_ctrl

Parametrised SQI (quad-SPI) serial SRAM controller that turns single-word read/write requests from the core into command, address, dummy and data nibble streams on a shared 4-bit SIO bus. It succeeds the fixed single-chip SQI path and generalises it in three ways: chip count, address width and word size. It also adds an optional sequential-burst mode. It sits between the core's memory port and the pads, and drives `sqi_mode_t` from `idli_pkg` to steer pad direction.

## Interface
- `NUM_CHIPS`, 2: number of SRAM chips sharing SIO and SCK, each with its own CS_n; ≥1.
- `ADDR_W`, 24: byte address width sent to the chip; multiple of 4; A = ADDR_W/4 address nibbles.
- `DATA_NIBBLES`, 4: nibbles per data word (D); even, ≥2; word width W = 4·D.
- `CHIP_W` (localparam): max(1, $clog2(NUM_CHIPS)).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_req` in 1: request valid.
- `o_ready` out 1: controller can accept; transfer occurs on `i_req && o_ready`.
- `i_we` in 1: 1 = write, 0 = read.
- `i_chip` in CHIP_W: target chip index.
- `i_addr` in ADDR_W: byte address.
- `i_wdata` in W: write data, MSB nibble sent first.
- `o_done` out 1: one-cycle pulse when a transaction's data phase completes.
- `o_rdata` out W: read data, valid while `o_done` is high after a read; holds its value otherwise.
- `o_sqi_sck` out 1: serial clock.
- `o_sqi_cs_n` out NUM_CHIPS: per-chip select, active low.
- `o_sqi_sio` out 4: outgoing nibble.
- `i_sqi_sio` in 4: incoming nibble.
- `o_sqi_mode` out `sqi_mode_t`: pad direction.

## Operation
- Each nibble occupies 2 `i_clk` cycles:
  - Phase 0: `o_sqi_sck`=0, and `o_sqi_sio` updates at the start of this phase.
  - Phase 1: `o_sqi_sck`=1; the chip samples on the rising edge.
  - `i_sqi_sio` is registered at the `i_clk` edge that ends phase 1.
- States:
  - IDLE: `o_ready`=1, all CS_n high. Acceptance moves to CMD.
  - CMD: 2 nibbles. Read sends 0x0,0x3; write sends 0x0,0x2.
  - ADDR: A nibbles, MSB first.
  - DUMMY: reads only, 2 nibbles, with `o_sqi_mode`=SQI_MODE_IN.
  - DATA: D nibbles. Writes shift out `i_wdata` (captured at acceptance) with mode OUT. Reads shift `i_sqi_sio` into `o_rdata` MSB-first with mode IN.
  - END: 2 cycles, all CS_n high, `o_done` pulses in the first cycle, then back to IDLE.
- `o_sqi_mode` is SQI_MODE_OUT in CMD/ADDR and in write DATA. It is SQI_MODE_IN in IDLE, END, DUMMY and read DATA.
- Only `o_sqi_cs_n[i_chip]` (the value captured at acceptance) goes low, from the first CMD cycle through the last DATA cycle.
- If `i_chip` ≥ NUM_CHIPS, the full sequence still runs, but no CS_n falls and a read returns `o_rdata`=0.
- Inputs other than `i_req` are ignored outside acceptance.

## Timing
- Reset values: `o_ready`=1, `o_done`=0, `o_rdata`=0, `o_sqi_sck`=0, `o_sqi_cs_n`=all 1, `o_sqi_sio`=0, `o_sqi_mode`=SQI_MODE_IN, state IDLE.
- Latency from the acceptance cycle to `o_done`:
  - Read: 2·(4+A+D) cycles.
  - Write: 2·(2+A+D) cycles.
  - With defaults: read 28, write 24.
- Back-to-back rate: the next acceptance is possible 2 cycles after `o_done`, when `o_ready` rises.
- Reset asserted mid-transaction: all outputs go to their reset values immediately (asynchronously). The transaction is abandoned and no `o_done` is issued.

## Configuration
- `IDLI_SQI_BURST_EN` defined:
  - `o_ready` is also high during phase 1 of the final DATA nibble.
  - A request accepted then that is a sequential continuation goes straight back to DATA next cycle. Sequential means: same `i_we`, same `i_chip`, and `i_addr` = previous + D/2. In this case CS_n stays low and there is no CMD/ADDR/DUMMY.
  - The previous `o_done` still pulses in that cycle.
  - A non-sequential request accepted then passes through END and then starts CMD; its latency increases by 2.
- `IDLI_SQI_BURST_EN` undefined: `o_ready` is high only in IDLE, and every transaction runs the full sequence.

## Test plan
- Reset: hold `i_rst_n`=0 → all outputs at reset values; release → `o_ready`=1 and SCK idle low.
- Write chip 0, addr 0x000010, data 0xBEEF → SIO nibbles 0,2,0,0,0,0,1,0,B,E,E,F, only `o_sqi_cs_n[0]` low, mode OUT throughout, `o_done` at cycle 24.
- Read chip 1, addr 0x00ABCD, model drives A,5,A,5 in DATA → mode IN from cycle 17, `o_rdata`=0xA5A5 with `o_done` at cycle 28, `o_sqi_cs_n`=2'b01 while active.
- Reset pulse at cycle 10 of a read → CS_n all high and mode IN immediately, no `o_done`, next request completes normally.
- Read with `i_chip`=3 when NUM_CHIPS=2 → no CS_n falls, `o_done` at cycle 28, `o_rdata`=0.
- Burst (macro defined): read 0x000100, then read 0x000102 presented at the final nibble → CS_n stays low, second `o_done` 8 cycles after the first. Then read 0x000200 → CS_n gap of 2 cycles and a full CMD.
